mdu_seq: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core. Sits in the E stage beside the ALU.
- Supports mult/multu/div/divu plus multiply-accumulate modes (madd/maddu/msub/msubu), mthi/mtlo and mfhi/mflo reads.
- Latencies are configurable.
- Exposes busy/stall_req to the hazard unit and a cancel input for pipeline flush.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_arith.sv | 83 ++++++++
 rtl/mdu_seq.sv | 123 ++++++++++++
 tb/tb_mdu_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and op-class helpers used by the sequencer and the arithmetic block.
package mdu_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MADD  = 4'd4,
        MADDU = 4'd5,
        MSUB  = 4'd6,
        MSUBU = 4'd7,
        MTHI  = 4'd8,
        MTLO  = 4'd9,
        MFHI  = 4'd10,
        MFLO  = 4'd11,
        NOP   = 4'd12
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Multiply-class ops (including the accumulate variants) use MULT_CYCLES.
    function automatic logic is_mult_class(input op_e op);
        return (op == MULT)  || (op == MULTU) || (op == MADD) || (op == MADDU) ||
               (op == MSUB)  || (op == MSUBU);
    endfunction

    // Divide-class ops use DIV_CYCLES.
    function automatic logic is_div_class(input op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational result generator. Produces the full {hi,lo} value
// an op would commit, including the divide-by-zero and signed-overflow
// special cases, so the sequencer only has to delay it.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e                  op_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [WIDTH-1:0]     hi_i,
    input  logic [WIDTH-1:0]     lo_i,
    output logic [2*WIDTH-1:0]   res_o
);

    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Products: the low 2*WIDTH bits of a product of sign-extended operands
    // equal the two's-complement signed product, so one multiplier shape
    // serves both flavours.
    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u, acc;

    assign a_sx   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_sx   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign a_zx   = {ZERO, a_i};
    assign b_zx   = {ZERO, b_i};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;
    assign acc    = {hi_i, lo_i};

    // Signed division is done on magnitudes with an unsigned divider, then
    // the signs are restored; this avoids relying on signed '/' semantics at
    // the overflow corner. The divisor is forced non-zero so the divider
    // itself never sees zero; the zero case is replaced below anyway.
    logic [WIDTH-1:0] a_mag, b_mag, b_sdiv, q_mag, r_mag, q_s, r_s;
    logic [WIDTH-1:0] b_udiv, q_u, r_u;

    assign a_mag  = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag  = b_i[WIDTH-1] ? -b_i : b_i;
    assign b_sdiv = (b_mag == ZERO) ? ONE : b_mag;
    assign q_mag  = a_mag / b_sdiv;
    assign r_mag  = a_mag % b_sdiv;
    assign q_s    = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) ? -q_mag : q_mag;
    assign r_s    = a_i[WIDTH-1] ? -r_mag : r_mag;

    assign b_udiv = (b_i == ZERO) ? ONE : b_i;
    assign q_u    = a_i / b_udiv;
    assign r_u    = a_i % b_udiv;

    // Select the {hi,lo} result for the requested op.
    always_comb begin
        res_o = acc;
        case (op_i)
            MULT:  res_o = prod_s;
            MULTU: res_o = prod_u;
            MADD:  res_o = acc + prod_s;
            MADDU: res_o = acc + prod_u;
            MSUB:  res_o = acc - prod_s;
            MSUBU: res_o = acc - prod_u;
            DIV: begin
                if (b_i == ZERO)
                    res_o = {a_i, ONES};
                else if ((a_i == MOST_NEG) && (b_i == ONES))
                    res_o = {ZERO, a_i};
                else
                    res_o = {r_s, q_s};
            end
            DIVU: begin
                if (b_i == ZERO)
                    res_o = {a_i, ONES};
                else
                    res_o = {r_u, q_u};
            end
            default: res_o = acc;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is
// computed at the start edge, parked in a pending register, and committed
// to HI/LO after a configurable number of busy cycles unless cancelled.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] arith_res;
    logic               mult_cls, div_cls, multi_cls, rd_op;

    assign mult_cls  = is_mult_class(op);
    assign div_cls   = is_div_class(op);
    assign multi_cls = mult_cls | div_cls;
    assign rd_op     = (op == MFHI) || (op == MFLO);

    // Mac ops read committed HI/LO; safe because start is ignored while busy.
    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op_i  (op),
        .a_i   (a),
        .b_i   (b),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .res_o (arith_res)
    );

    // Next-state: launch, count down, commit or cancel, and mthi/mtlo writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                // Cancel in the same cycle suppresses any launch or write.
                if (start && !cancel) begin
                    if (multi_cls) begin
                        pend_d  = arith_res;
                        cnt_d   = div_cls ? DIV_LOAD : MULT_LOAD;
                        state_d = RUN;
                    end else if (op == MTHI) begin
                        hi_d = a;
                    end else if (op == MTLO) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                // Cancel wins over a commit landing on the same edge.
                if (cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pend_d  = '0;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = pend_q;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign stall_req = busy | (start & multi_cls) | (start & rd_op & busy);
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Register read port: only committed values are visible.
    always_comb begin
        rdata = '0;
        if (op == MFHI)
            rdata = hi_q;
        else if (op == MFLO)
            rdata = lo_q;
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a table of ops with hand-computed HI/LO and
// busy lengths, followed by hand-written cancel, stall and reset sequences.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    op_e         op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy, stall_req;
    logic [31:0] hi, lo, rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Issue one op from a negedge, count busy cycles, then check HI/LO.
    task automatic run_op(input op_e o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
        int n;
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        #1;
        chk("stall_req at start", {31'd0, stall_req}, {31'd0, (cyc > 0)});
        @(negedge clk);
        start = 1'b0;
        op    = NOP;
        n     = 0;
        while (busy && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("busy cycles", n, cyc);
        chk("hi", hi, ehi);
        chk("lo", lo, elo);
        $display("op %s a=%h b=%h -> hi=%h lo=%h busy=%0d", o.name(), va, vb, hi, lo, n);
    endtask

    initial begin
        int n;
        vecs[0]  = '{MULT,  32'hFFFFFFFE, 32'd3,      32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{DIVU,  32'd100,      32'd7,      32'd2,        32'd14,       10};
        vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'd2,      32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,      32'hFFFFFFFD, 10};
        vecs[5]  = '{MTHI,  32'd1,        32'd0,      32'd1,        32'hFFFFFFFD, 0};
        vecs[6]  = '{MTLO,  32'hFFFFFFFF, 32'd0,      32'd1,        32'hFFFFFFFF, 0};
        vecs[7]  = '{MADDU, 32'd1,        32'd1,      32'd2,        32'd0,        5};
        vecs[8]  = '{MSUB,  32'd1,        32'd1,      32'd1,        32'hFFFFFFFF, 5};
        vecs[9]  = '{MADD,  32'hFFFFFFFF, 32'd2,      32'd1,        32'hFFFFFFFD, 5};
        vecs[10] = '{MSUBU, 32'hFFFFFFFF, 32'd2,      32'hFFFFFFFF, 32'hFFFFFFFF, 5};
        vecs[11] = '{DIV,   32'd5,        32'd0,      32'd5,        32'hFFFFFFFF, 10};
        vecs[12] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,      32'h80000000, 10};
        vecs[13] = '{DIVU,  32'd9,        32'd0,      32'd9,        32'hFFFFFFFF, 10};
        vecs[14] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,      10};

        reset  = 1'b0;
        start  = 1'b0;
        op     = NOP;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc);

        // Read port and idle stall behaviour (hi=FFFFFFFF, lo=3).
        op = MFHI;
        #1;
        chk("rdata mfhi", rdata, 32'hFFFFFFFF);
        op = MFLO;
        start = 1'b1;
        #1;
        chk("rdata mflo", rdata, 32'd3);
        chk("stall mflo idle", {31'd0, stall_req}, 32'd0);
        op = NOP;
        #1;
        chk("rdata nop", rdata, 32'd0);
        start = 1'b0;
        @(negedge clk);

        // Cancel mid-op, with an mthi attempted while busy.
        start = 1'b1; op = MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        op = MTHI; a = 32'h55;
        #1;
        chk("stall while busy", {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        start = 1'b0; op = NOP; cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", {31'd0, busy}, 32'd0);
        chk("cancel hi", hi, 32'hFFFFFFFF);
        chk("cancel lo", lo, 32'd3);
        repeat (8) @(negedge clk);
        chk("cancel no late hi", hi, 32'hFFFFFFFF);
        chk("cancel no late lo", lo, 32'd3);
        $display("cancel mid-op: hi=%h lo=%h", hi, lo);

        // Cancel together with start in IDLE.
        start = 1'b1; op = MTLO; a = 32'h77; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; op = NOP; cancel = 1'b0;
        chk("cancel+start lo", lo, 32'd3);
        chk("cancel+start busy", {31'd0, busy}, 32'd0);
        $display("cancel with mtlo: lo=%h", lo);

        // Cancel on the commit edge wins.
        start = 1'b1; op = MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; op = NOP;
        repeat (4) @(negedge clk);
        chk("last busy cycle", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("commit-cancel busy", {31'd0, busy}, 32'd0);
        chk("commit-cancel hi", hi, 32'hFFFFFFFF);
        chk("commit-cancel lo", lo, 32'd3);
        $display("cancel on commit edge: hi=%h lo=%h", hi, lo);

        run_op(MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);

        // mfhi held while a divide runs: stall until commit, then read.
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        op = MFHI;
        n  = 0;
        #1;
        while (stall_req && n < 60) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("mfhi stall cycles", n, 10);
        chk("mfhi rdata", rdata, 32'd2);
        op = MFLO;
        #1;
        chk("mflo rdata", rdata, 32'd14);
        start = 1'b0; op = NOP;
        $display("mfhi during divu: stalled %0d cycles, hi=%h lo=%h", n, hi, lo);
        @(negedge clk);

        // Asynchronous reset mid-divide.
        start = 1'b1; op = DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = NOP;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset hi", hi, 32'd0);
        chk("async reset lo", lo, 32'd0);
        $display("reset mid-div: busy=%0d hi=%h lo=%h", busy, hi, lo);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post reset busy", {31'd0, busy}, 32'd0);
        run_op(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
